// File: rtl/operand_fetch.sv
// operand_fetch: register-read / operand-issue stage ahead of the ALU.
//
// Holds the NREGS x DATA_W architectural register file, reads two source
// operands (with same-cycle writeback bypass), selects the immediate for B,
// and presents {opcode, a, b, rd, wr} through a one-entry output register.
// A pending-bit scoreboard tracks in-flight destinations and stalls issue on
// RAW/WAW hazards. DATA_W is expected to match the project word size.
//
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   in_valid / in_ready   instruction handshake from decode
//   in_opcode, in_rs1, in_rs2, in_rd, in_wr, in_use_imm, in_imm
//                         decoded instruction fields
//   out_valid / out_ready operand handshake to the ALU
//   out_opcode, out_a, out_b, out_rd, out_wr
//                         registered operand bundle
//   wb_en, wb_addr, wb_data
//                         writeback from the downstream stage
module operand_fetch #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opcode,
  input  logic [AW-1:0]     in_rs1,
  input  logic [AW-1:0]     in_rs2,
  input  logic [AW-1:0]     in_rd,
  input  logic              in_wr,
  input  logic              in_use_imm,
  input  logic [DATA_W-1:0] in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_opcode,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [AW-1:0]     out_rd,
  output logic              out_wr,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data
);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  pending;

  logic [DATA_W-1:0] rs1_val;
  logic [DATA_W-1:0] rs2_val;
  logic              raw1;
  logic              raw2;
  logic              waw;
  logic              hazard;
  logic              accept;

  // Operand read with writeback bypass; r0 always reads zero.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (in_rs1 != '0)
      rs1_val = (wb_en && wb_addr == in_rs1) ? wb_data : regs[in_rs1];
    if (in_rs2 != '0)
      rs2_val = (wb_en && wb_addr == in_rs2) ? wb_data : regs[in_rs2];
  end

  // A same-cycle writeback to a pending register resolves the hazard.
  always_comb begin
    raw1   = (in_rs1 != '0) && pending[in_rs1] && !(wb_en && wb_addr == in_rs1);
    raw2   = !in_use_imm && (in_rs2 != '0) && pending[in_rs2] &&
             !(wb_en && wb_addr == in_rs2);
    waw    = in_wr && (in_rd != '0) && pending[in_rd] &&
             !(wb_en && wb_addr == in_rd);
    hazard = in_valid && (raw1 || raw2 || waw);
  end

  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // Register file; r0 is never written so it stays zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_en && wb_addr != '0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Scoreboard: the set on accept is applied after the writeback clear so
  // that a re-issue to the same destination keeps the register pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      logic [NREGS-1:0] nxt;
      nxt = pending;
      if (wb_en && wb_addr != '0) nxt[wb_addr] = 1'b0;
      if (accept && in_wr && in_rd != '0) nxt[in_rd] = 1'b1;
      pending <= nxt;
    end
  end

  // One-entry output register; payload only changes on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_opcode <= '0;
      out_a      <= '0;
      out_b      <= '0;
      out_rd     <= '0;
      out_wr     <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_opcode <= in_opcode;
      out_a      <= rs1_val;
      out_b      <= in_use_imm ? in_imm : rs2_val;
      out_rd     <= in_rd;
      out_wr     <= in_wr;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Testbench for operand_fetch: directed scenarios with literal expectations,
// then randomized traffic checked cycle-by-cycle against a behavioural model.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_opcode;
  logic [2:0]  in_rs1, in_rs2, in_rd;
  logic        in_wr, in_use_imm;
  logic [15:0] in_imm;
  logic        out_valid, out_ready;
  logic [4:0]  out_opcode;
  logic [15:0] out_a, out_b;
  logic [2:0]  out_rd;
  logic        out_wr;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;

  operand_fetch #(.DATA_W(16), .NREGS(8), .AW(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_wr(in_wr),
    .in_use_imm(in_use_imm), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_a(out_a), .out_b(out_b), .out_rd(out_rd), .out_wr(out_wr),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state
  logic [15:0] mregs [8];
  bit          mpend [8];
  bit          m_ov;
  logic [4:0]  m_op;
  logic [15:0] m_a, m_b;
  logic [2:0]  m_rd;
  logic        m_wr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin mregs[i] = '0; mpend[i] = 0; end
    m_ov = 0; m_op = '0; m_a = '0; m_b = '0; m_rd = '0; m_wr = 0;
  endtask

  function automatic logic [15:0] mread(input logic [2:0] r);
    if (r == 0) return 16'h0;
    if (wb_en && wb_addr == r) return wb_data;
    return mregs[r];
  endfunction

  function automatic bit mblocked(input logic [2:0] r);
    return (r != 0) && mpend[r] && !(wb_en && wb_addr == r);
  endfunction

  function automatic bit m_ready();
    bit haz;
    haz = in_valid && (mblocked(in_rs1) || (!in_use_imm && mblocked(in_rs2)) ||
                       (in_wr && mblocked(in_rd)));
    return (!m_ov || out_ready) && !haz;
  endfunction

  task automatic drive(input logic v, input logic [4:0] op, input logic [2:0] r1,
                       input logic [2:0] r2, input logic [2:0] rd, input logic wr,
                       input logic ui, input logic [15:0] imm, input logic ordy,
                       input logic wbe, input logic [2:0] wba, input logic [15:0] wbd);
    in_valid = v; in_opcode = op; in_rs1 = r1; in_rs2 = r2; in_rd = rd;
    in_wr = wr; in_use_imm = ui; in_imm = imm; out_ready = ordy;
    wb_en = wbe; wb_addr = wba; wb_data = wbd;
    #1;
  endtask

  // Check in_ready, advance the model across one clock edge, check outputs.
  task automatic tick();
    bit          acc;
    logic [15:0] na, nb;
    acc = in_valid && m_ready();
    chk("in_ready", in_ready, m_ready());
    na = mread(in_rs1);
    nb = in_use_imm ? in_imm : mread(in_rs2);
    if (wb_en && wb_addr != 0) begin
      mregs[wb_addr] = wb_data;
      mpend[wb_addr] = 0;
    end
    if (acc && in_wr && in_rd != 0) mpend[in_rd] = 1;
    if (acc) begin
      m_ov = 1; m_op = in_opcode; m_a = na; m_b = nb; m_rd = in_rd; m_wr = in_wr;
    end else if (out_ready) begin
      m_ov = 0;
    end
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, m_ov);
    chk("out_opcode", out_opcode, m_op);
    chk("out_a", out_a, m_a);
    chk("out_b", out_b, m_b);
    chk("out_rd", out_rd, m_rd);
    chk("out_wr", out_wr, m_wr);
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    in_valid = 0; in_opcode = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_wr = 0;
    in_use_imm = 0; in_imm = 0; out_ready = 1; wb_en = 0; wb_addr = 0; wb_data = 0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_a", out_a, 0);
    chk("rst_out_b", out_b, 0);
    chk("rst_out_rd_op_wr", {out_opcode, out_rd, out_wr}, 0);
    chk("rst_in_ready", in_ready, 1);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Load r1=5, r2=-3
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 16'd5);       tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 16'hFFFD);    tick();
    // ADD r3 = r1 + r2, held by out_ready=0
    drive(1, 1, 1, 2, 3, 1, 0, 0, 0, 0, 0, 0);           tick();
    chk("add_valid", out_valid, 1);
    chk("add_a", out_a, 16'd5);
    chk("add_b", out_b, 16'hFFFD);
    chk("add_rd", out_rd, 3);
    // SUB reading pending r3: stall, prior entry drains
    drive(1, 2, 3, 0, 6, 1, 0, 0, 1, 0, 0, 0);
    chk("raw_stall_ready", in_ready, 0);
    tick();
    chk("raw_stall_drain", out_valid, 0);
    // Same instruction with wb r3=2 -> bypass
    drive(1, 2, 3, 0, 6, 1, 0, 0, 1, 1, 3, 16'd2);
    chk("raw_bypass_ready", in_ready, 1);
    tick();
    chk("raw_bypass_a", out_a, 16'd2);
    // CMP rd=4 wr=0, then read r4 -> no stall
    drive(1, 3, 1, 2, 4, 0, 0, 0, 1, 0, 0, 0);           tick();
    drive(1, 1, 4, 1, 7, 1, 0, 0, 1, 0, 0, 0);
    chk("cmp_no_stall", in_ready, 1);
    tick();
    // wb to r0 ignored; r0 reads 0
    drive(1, 4, 0, 0, 0, 0, 1, 16'd9, 1, 1, 0, 16'd7);   tick();
    chk("r0_a", out_a, 0);
    chk("r0_b_imm", out_b, 16'd9);
    // Backpressure for 3 cycles
    drive(1, 9, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("bp_ready", in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_hold_op", out_opcode, 4);
      chk("bp_hold_b", out_b, 16'd9);
    end
    drive(1, 9, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("bp_release_ready", in_ready, 1);
    tick();
    chk("bp_release_op", out_opcode, 9);
    chk("bp_release_a", out_a, 16'd5);
    // Back-to-back on r5
    drive(1, 1, 1, 1, 5, 1, 0, 0, 1, 0, 0, 0);           tick();
    drive(1, 1, 5, 1, 2, 1, 0, 0, 1, 0, 0, 0);
    chk("r5_stall", in_ready, 0);
    tick(); tick();
    drive(1, 1, 5, 1, 5, 1, 0, 0, 1, 1, 5, 16'h1234);
    chk("r5_wb_ready", in_ready, 1);
    tick();
    chk("r5_bypass_a", out_a, 16'h1234);
    drive(1, 1, 5, 1, 2, 1, 0, 0, 1, 0, 0, 0);
    chk("r5_still_pending", in_ready, 0);
    // Reset mid-operation
    rst = 1'b1;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_ready", in_ready, 1);
    chk("midrst_a", out_a, 0);
    model_reset();
    rst = 1'b0;
    drive(1, 1, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0);           tick();
    chk("postrst_a", out_a, 0);
    chk("postrst_b", out_b, 0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [2:0] wa;
      int unsigned np;
      logic [2:0] plist [$];
      plist = {};
      for (int r = 1; r < 8; r++) if (mpend[r]) plist.push_back(3'(r));
      np = plist.size();
      wa = ($urandom_range(0, 3) != 0 && np != 0) ? plist[$urandom_range(0, np - 1)]
                                                  : 3'($urandom_range(0, 7));
      drive($urandom_range(0, 3) != 0, 5'($urandom), 3'($urandom), 3'($urandom),
            3'($urandom), 1'($urandom), 1'($urandom), 16'($urandom),
            $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, wa, 16'($urandom));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Register-read / operand-issue stage directly upstream of the ALU.
- Holds the architectural register file (NREGS x DATA_W), reads two source operands, selects immediate for B, and presents {opcode, a, b, rd} to the ALU through a one-entry output pipeline register.
- Tracks in-flight destination registers with a pending-bit scoreboard and stalls on RAW/WAW hazards.
- Accepts writeback from the downstream stage, with same-cycle bypass.

Parameters:
- DATA_W, 16, operand width; must equal the project WORD_SIZE macro.
- NREGS, 8, number of registers; register 0 reads as zero.
- AW, 3, register address width; NREGS = 2**AW.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction offered by decode.
- in_ready  out  1  stage accepts instruction this cycle.
- in_opcode  in  5  ALU opcode, passed through unmodified.
- in_rs1  in  AW  source A register.
- in_rs2  in  AW  source B register; ignored when in_use_imm=1.
- in_rd  in  AW  destination register.
- in_wr  in  1  instruction writes rd (0 for CMP).
- in_use_imm  in  1  B operand = in_imm.
- in_imm  in  DATA_W  immediate, already sign-extended.
- out_valid  out  1  operands valid to ALU.
- out_ready  in  1  ALU/execute consumes this cycle.
- out_opcode  out  5  registered opcode.
- out_a  out  DATA_W  registered operand A (signed).
- out_b  out  DATA_W  registered operand B (signed).
- out_rd  out  AW  registered destination.
- out_wr  out  1  registered write flag.
- wb_en  in  1  writeback strobe.
- wb_addr  in  AW  writeback register.
- wb_data  in  DATA_W  writeback value.

Behaviour:
- Reset (async, immediate):
  - all registers = 0, all pending bits = 0.
  - out_valid = 0; out_opcode, out_a, out_b, out_rd, out_wr = 0.
- Reset asserted mid-operation discards the held output entry and all scoreboard state. Nothing is replayed.
- Register read:
  - combinational from the array, with bypass: if wb_en && wb_addr == rsX && rsX != 0, the read value is wb_data.
  - rsX == 0 reads 0 regardless of array or bypass.
- Writeback:
  - on the clock edge, if wb_en && wb_addr != 0, write wb_data and clear pending[wb_addr].
  - Writes to r0 are ignored.
- Hazard (evaluated only when in_valid=1):
  - RAW on rs1: rs1 != 0, pending[rs1] = 1, and not (wb_en && wb_addr == rs1).
  - RAW on rs2: same test, applied only when in_use_imm = 0.
  - WAW: in_wr, in_rd != 0, pending[in_rd] = 1, and not bypassed by a same-cycle writeback.
  - hazard = OR of the above.
- Handshake:
  - in_ready = (!out_valid || out_ready) && !hazard. in_ready is combinational and holds no dependence on its own value.
  - accept = in_valid && in_ready.
  - On accept: capture opcode, a, b (in_imm if in_use_imm, else rs2 value), rd, wr; out_valid <= 1.
  - If out_ready && out_valid && !accept: out_valid <= 0.
  - Outputs are held stable while out_valid && !out_ready.
- Latency: 1 cycle from accept to out_valid. Sustained throughput is 1/cycle with no hazards and out_ready=1.
- Scoreboard:
  - on accept with in_wr && in_rd != 0, set pending[in_rd].
  - If a writeback clears the same register in the same cycle, the set wins.
- Writeback to a non-pending register is legal: it writes the array and leaves pending = 0.
- No arithmetic or width conversion in this stage. Values pass bit-exact.

Test Plan:
- Reset then write r1=5, r2=-3 via wb; issue ADD rs1=1 rs2=2 rd=3 wr=1 -> next cycle out_valid=1, out_a=5, out_b=0xFFFD, out_rd=3, pending[3]=1.
- Issue SUB rs1=3 while pending[3]=1 and no wb -> in_ready=0, out_valid drops after the ALU consumes the prior entry. Then wb r3=2 in the same cycle -> in_ready=1, out_a=2 via bypass.
- CMP with in_wr=0, rd=4, followed by an instruction reading r4 -> no stall. Read r0 after wb_addr=0, wb_data=7 -> out_a=0.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs constant. Release -> next instruction issues the following cycle.
- Back-to-back ADDs writing rd=5, second reading rs1=5 -> stall until wb_addr=5. Same-cycle wb r5 plus issue with rd=5 -> pending[5] remains 1.
- Assert rst while out_valid=1 and pending bits set -> out_valid=0 and pending=0 immediately; all registers read 0 afterwards.
